// File: rtl/if_stage_pkg.sv
// Fetch-stage shared bus macros, types and FSM state encodings.
// IF_PERF_CNT_EN in if_stage adds fetch/stall performance counters.
`ifndef IF_STAGE_DEFS
`define IF_STAGE_DEFS
`define INST_BUS [31:0]
`define ADDR_BUS [63:0]
`define PC_START 64'h80000000
`endif

package if_stage_pkg;

  typedef logic `INST_BUS inst_t;
  typedef logic `ADDR_BUS addr_t;

  localparam addr_t PC_START = `PC_START;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, single-outstanding fetch FSM.
// Define IF_PERF_CNT_EN to add perf_fetch_cnt/perf_stall_cnt outputs.
module if_stage
  import if_stage_pkg::*;
#(
  parameter addr_t       PC_RESET = PC_START,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  redirect_valid,
  input  addr_t redirect_pc,
  output logic  inst_req_valid,
  input  logic  inst_req_ready,
  output addr_t inst_req_addr,
  input  logic  inst_rsp_valid,
  input  inst_t inst_rsp_data,
  output logic  out_valid,
  input  logic  out_ready,
  output addr_t out_pc,
  output inst_t out_inst
`ifdef IF_PERF_CNT_EN
  ,
  output logic [63:0] perf_fetch_cnt,
  output logic [63:0] perf_stall_cnt
`endif
);

  localparam addr_t STEP = addr_t'(PC_STEP);

  state_t state, state_n;
  addr_t  pc, pc_n;
  logic   drop, drop_n;
  logic   ov_n;
  addr_t  opc_n;
  inst_t  oinst_n;
  addr_t  redir;

  wire unused_lo = &{1'b0, redirect_pc[1:0]};

  assign redir          = {redirect_pc[63:2], 2'b00};
  assign inst_req_valid = (state == S_REQ);
  assign inst_req_addr  = pc;

  always_comb begin
    state_n = state;
    pc_n    = pc;
    drop_n  = drop;
    ov_n    = out_valid;
    opc_n   = out_pc;
    oinst_n = out_inst;
    unique case (state)
      S_REQ: begin
        if (redirect_valid) begin
          pc_n = redir;
          // request already left: its response must be dropped
          if (inst_req_ready) begin
            state_n = S_WAIT;
            drop_n  = 1'b1;
          end
        end else if (inst_req_ready) begin
          state_n = S_WAIT;
          drop_n  = 1'b0;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_n = redir;
          if (inst_rsp_valid) begin
            state_n = S_REQ;
            drop_n  = 1'b0;
          end else begin
            drop_n = 1'b1;
          end
        end else if (inst_rsp_valid) begin
          if (drop) begin
            drop_n  = 1'b0;
            state_n = S_REQ;
          end else begin
            ov_n    = 1'b1;
            opc_n   = pc;
            oinst_n = inst_rsp_data;
            state_n = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_n    = redir;
          ov_n    = 1'b0;
          state_n = S_REQ;
        end else if (out_ready) begin
          pc_n    = pc + STEP;
          ov_n    = 1'b0;
          state_n = S_REQ;
        end
      end
      default: begin
        state_n = S_REQ;
        ov_n    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_REQ;
      pc        <= PC_RESET;
      drop      <= 1'b0;
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_inst  <= '0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      drop      <= drop_n;
      out_valid <= ov_n;
      out_pc    <= opc_n;
      out_inst  <= oinst_n;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic handoff;
  logic stall;

  // a redirect cancels the handoff in the same cycle
  assign handoff = out_valid & out_ready & ~redirect_valid;
  assign stall   = out_valid & ~out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (handoff) perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
      if (stall)   perf_stall_cnt <= perf_stall_cnt + 64'd1;
    end
  end
`endif

endmodule
